// File: rtl/scan_seq.sv
// scan_seq: scan sequencer for the 16x4-bit register bank.
//
// A start request latches a register range. The sequencer then walks the
// 6-bit address {rg_a, bit_a} from {first_rg, 0} to {last_rg, 3}. The walk
// wraps modulo 64, so a range with last_rg < first_rg passes through
// register 15 and on to register 0. For each address it fetches one bit from
// the bank and offers that bit downstream over a valid/ready handshake. It
// pulses done once the last bit has been accepted.
//
// Ports:
//   tick      clock, rising edge
//   clr_n     synchronous active-low reset
//   start     scan request, honoured only while idle
//   abort     cancel the scan, honoured in any non-idle state
//   first_rg  first register of the range, latched on accepted start
//   last_rg   last register of the range, latched on accepted start
//   rd_bit    bank read data at (rg_a, bit_a), combinational from the bank
//   out_rdy   downstream ready
//   rg_a      bank register address (registered)
//   bit_a     bank bit address (registered)
//   out_bit   scan data (registered)
//   out_vld   out_bit valid
//   busy      high in every state except idle
//   done      one-cycle pulse at normal completion
//   nbits     number of accepted beats in the current or last scan, 0..64
module scan_seq (
  input  logic       tick,
  input  logic       clr_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] first_rg,
  input  logic [3:0] last_rg,
  input  logic       rd_bit,
  input  logic       out_rdy,
  output logic [3:0] rg_a,
  output logic [1:0] bit_a,
  output logic       out_bit,
  output logic       out_vld,
  output logic       busy,
  output logic       done,
  output logic [6:0] nbits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t     state;
  logic [5:0] addr;
  logic [3:0] first_q;
  logic [3:0] last_q;

  // Number of registers in the range, 1..16. The subtraction wraps modulo
  // 16, so first_q == last_q + 1 yields the full bank.
  logic [4:0] span;
  logic [6:0] scan_len;
  logic       at_end;

  assign span     = {1'b0, last_q - first_q} + 5'd1;
  assign scan_len = {span, 2'b00};
  assign at_end   = (addr == {last_q, 2'b11});

  assign {rg_a, bit_a} = addr;

  // busy, out_vld and done are registered flags. Each is set or cleared in
  // the same edge that enters the matching state, so they always agree with
  // the state register.
  always_ff @(posedge tick) begin
    if (!clr_n) begin
      state   <= S_IDLE;
      addr    <= '0;
      first_q <= '0;
      last_q  <= '0;
      out_bit <= 1'b0;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nbits   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          out_vld <= 1'b0;
          done    <= 1'b0;
          // abort has no meaning here, so start wins even if both are high
          if (start) begin
            first_q <= first_rg;
            last_q  <= last_rg;
            addr    <= {first_rg, 2'b00};
            nbits   <= '0;
            busy    <= 1'b1;
            state   <= S_FETCH;
          end else begin
            busy <= 1'b0;
          end
        end

        S_FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            // The address has been stable for a full cycle by now
            out_bit <= rd_bit;
            out_vld <= 1'b1;
            state   <= S_SEND;
          end
        end

        S_SEND: begin
          // A beat that is accepted in the same cycle as abort still counts
          if (out_rdy) begin
            nbits <= nbits + 7'd1;
          end
          if (abort) begin
            out_vld <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (out_rdy) begin
            out_vld <= 1'b0;
            if (at_end) begin
              // The address walk and the beat count must agree at the end
              assert (nbits + 7'd1 == scan_len);
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              addr  <= addr + 6'd1;
              state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          // done is already high this cycle, so abort changes nothing here
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq.sv
// Testbench for scan_seq. The reference model tracks the scan as a base
// address, a position within the range, a target length and an accepted-beat
// count. On every falling edge the DUT outputs are compared against that
// model, and the model is then advanced using the inputs that the next
// rising edge will see.
module tb_scan_seq;

  logic       tick = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] first_rg = '0;
  logic [3:0] last_rg = '0;
  logic       rd_bit;
  logic       out_rdy = 1'b0;
  logic [3:0] rg_a;
  logic [1:0] bit_a;
  logic       out_bit;
  logic       out_vld;
  logic       busy;
  logic       done;
  logic [6:0] nbits;

  logic [3:0] bank [16];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int q_rg[$];
  int q_ba[$];
  int q_bit[$];

  assign rd_bit = bank[rg_a][bit_a];

  scan_seq dut (
    .tick(tick),
    .clr_n(clr_n),
    .start(start),
    .abort(abort),
    .first_rg(first_rg),
    .last_rg(last_rg),
    .rd_bit(rd_bit),
    .out_rdy(out_rdy),
    .rg_a(rg_a),
    .bit_a(bit_a),
    .out_bit(out_bit),
    .out_vld(out_vld),
    .busy(busy),
    .done(done),
    .nbits(nbits)
  );

  always #5 tick = ~tick;
  always @(posedge tick) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model plus the per-cycle comparison.
  initial begin
    int  m_base, m_pos, m_len, m_nbits, a;
    bit  m_busy, m_vld, m_done, m_bit;
    m_base = 0; m_pos = 0; m_len = 0; m_nbits = 0;
    m_busy = 0; m_vld = 0; m_done = 0; m_bit = 0;
    forever begin
      @(negedge tick);
      a = (m_base + m_pos) % 64;
      chk("rg_a", rg_a, a / 4);
      chk("bit_a", bit_a, a % 4);
      chk("out_bit", out_bit, m_bit);
      chk("out_vld", out_vld, m_vld);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("nbits", nbits, m_nbits);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (clr_n && out_vld && out_rdy) begin
        q_rg.push_back(rg_a);
        q_ba.push_back(bit_a);
        q_bit.push_back(out_bit);
      end
      // advance to the state after the coming rising edge
      if (!clr_n) begin
        m_base = 0; m_pos = 0; m_len = 0; m_nbits = 0;
        m_busy = 0; m_vld = 0; m_done = 0; m_bit = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_base  = int'(first_rg) * 4;
          m_pos   = 0;
          m_len   = ((int'(last_rg) - int'(first_rg) + 16) % 16 + 1) * 4;
          m_nbits = 0;
          m_busy  = 1;
        end
      end else if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (!m_vld) begin
        if (abort) m_busy = 0;
        else begin
          m_bit = bank[a / 4][a % 4];
          m_vld = 1;
        end
      end else begin
        if (out_rdy) m_nbits++;
        if (abort) begin
          m_busy = 0;
          m_vld  = 0;
        end else if (out_rdy) begin
          m_vld = 0;
          if (m_nbits == m_len) m_done = 1;
          else m_pos++;
        end
      end
    end
  end

  task automatic cyc1();
    @(posedge tick);
    #2;
  endtask

  task automatic launch(input logic [3:0] f, input logic [3:0] l);
    q_rg.delete();
    q_ba.delete();
    q_bit.delete();
    first_rg = f;
    last_rg  = l;
    start    = 1'b1;
    cyc1();
    start_cyc = cyc;
    start     = 1'b0;
    // the range must already be latched, so scramble the inputs
    first_rg = 4'($urandom);
    last_rg  = 4'($urandom);
  endtask

  task automatic drain(input int rdy_pct, input bit spam, input int abort_pm,
                       input int limit);
    int n = 0;
    while (busy && n < limit) begin
      out_rdy = ($urandom_range(99) < rdy_pct);
      start   = spam && ($urandom_range(3) == 0);
      abort   = ($urandom_range(999) < abort_pm);
      cyc1();
      n++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (busy) chk("drain_timeout", busy, 0);
  endtask

  initial begin
    int d0, n;
    for (int i = 0; i < 16; i++) bank[i] = 4'($urandom);
    bank[7] = 4'b1010;
    bank[3] = 4'b0110;

    clr_n = 1'b0;
    cyc1();
    cyc1();
    clr_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_nbits", nbits, 0);
    chk("rst_addr", {rg_a, bit_a}, 0);

    // single register 7 = 1010
    d0 = done_cnt;
    launch(4'd7, 4'd7);
    drain(100, 0, 0, 100);
    chk("single_beats", q_bit.size(), 4);
    if (q_bit.size() == 4) begin
      chk("single_b0", q_bit[0], 0);
      chk("single_b1", q_bit[1], 1);
      chk("single_b2", q_bit[2], 0);
      chk("single_b3", q_bit[3], 1);
      chk("single_ba3", q_ba[3], 3);
    end
    chk("single_nbits", nbits, 4);
    chk("single_latency", done_cyc - start_cyc, 8);
    chk("single_done_cnt", done_cnt - d0, 1);

    // wrap-around 14..1
    launch(4'd14, 4'd1);
    drain(100, 0, 0, 200);
    chk("wrap_beats", q_rg.size(), 16);
    if (q_rg.size() == 16) begin
      chk("wrap_rg0", q_rg[0], 14);
      chk("wrap_rg4", q_rg[4], 15);
      chk("wrap_rg8", q_rg[8], 0);
      chk("wrap_rg12", q_rg[12], 1);
    end
    chk("wrap_nbits", nbits, 16);
    chk("wrap_end_rg", rg_a, 1);
    chk("wrap_end_bit", bit_a, 3);

    // full scan 5..4
    d0 = done_cnt;
    launch(4'd5, 4'd4);
    drain(100, 0, 0, 400);
    chk("full_beats", q_rg.size(), 64);
    if (q_rg.size() == 64) begin
      chk("full_pre_wrap", q_rg[43] * 4 + q_ba[43], 63);
      chk("full_post_wrap", q_rg[44] * 4 + q_ba[44], 0);
    end
    chk("full_nbits", nbits, 64);
    chk("full_done_cnt", done_cnt - d0, 1);
    chk("full_latency", done_cyc - start_cyc, 128);

    // backpressure on register 3 = 0110
    launch(4'd3, 4'd3);
    drain(40, 1, 0, 400);
    chk("bp_beats", q_bit.size(), 4);
    for (int i = 0; i < q_bit.size() && i < 4; i++) begin
      chk("bp_bit", q_bit[i], int'(bank[3][i]));
      chk("bp_ba", q_ba[i], i);
    end
    chk("bp_nbits", nbits, 4);

    // reset after three beats of a 2..5 scan
    d0 = done_cnt;
    launch(4'd2, 4'd5);
    out_rdy = 1'b1;
    n = 0;
    while (q_rg.size() < 3 && n < 100) begin
      cyc1();
      n++;
    end
    chk("mid_rst_beats", q_rg.size(), 3);
    clr_n = 1'b0;
    cyc1();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_bit", out_bit, 0);
    chk("mid_rst_addr", {rg_a, bit_a}, 0);
    chk("mid_rst_nbits", nbits, 0);
    clr_n = 1'b1;
    cyc1();
    chk("mid_rst_no_done", done_cnt - d0, 0);

    // abort coincident with the second accepted beat
    d0 = done_cnt;
    launch(4'd10, 4'd12);
    out_rdy = 1'b1;
    n = 0;
    while (!(out_vld && nbits == 7'd1) && n < 100) begin
      cyc1();
      n++;
    end
    chk("abort_reach", nbits, 1);
    abort    = 1'b1;
    start    = 1'b1;
    first_rg = 4'd9;
    last_rg  = 4'd9;
    cyc1();
    chk("abort_idle", busy, 0);
    chk("abort_nbits", nbits, 2);
    chk("abort_no_done", done, 0);
    cyc1();
    chk("restart_busy", busy, 1);
    chk("restart_addr", {rg_a, bit_a}, 36);
    start = 1'b0;
    abort = 1'b0;
    drain(100, 0, 0, 100);
    chk("restart_nbits", nbits, 4);
    chk("abort_done_cnt", done_cnt - d0, 1);

    // randomized scans
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 16; i++) bank[i] = 4'($urandom);
      launch(4'($urandom), 4'($urandom));
      drain($urandom_range(100, 30), 1, 8, 800);
      cyc1();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
